// File: rtl/picosoc_bus_arbiter.sv
// rtl/picosoc_bus_arbiter.sv - two-master round-robin bus arbiter with lock and slave watchdog
module picosoc_bus_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_valid,
    input  logic        m0_lock,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,
    input  logic        m1_valid,
    input  logic        m1_lock,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,
    output logic        s_valid,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic        s_ready,
    input  logic [31:0] s_rdata,
    output logic [1:0]  grant,
    input  logic        err_clear,
    output logic        timeout_err,
    output logic [31:0] timeout_addr
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam logic        WD_EN    = (TIMEOUT_CYCLES != 0);
    localparam logic [31:0] WD_LIMIT = (TIMEOUT_CYCLES != 0) ? TIMEOUT_CYCLES - 1 : 32'd0;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [1:0]  r_grant;
    logic [1:0]  w_grant_nxt;
    logic        r_ptr;
    logic        w_ptr_nxt;
    logic [31:0] r_wdog;
    logic        w_wdog_clr;
    logic        r_timeout_err;
    logic [31:0] r_timeout_addr;

    logic        w_sel_valid;
    logic        w_sel_lock;
    logic [31:0] w_sel_addr;
    logic [31:0] w_sel_wdata;
    logic [3:0]  w_sel_wstrb;
    logic        w_busy;
    logic        w_expire;
    logic        w_done;
    logic [31:0] w_done_rdata;

    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_lock  = 1'b0;
        w_sel_addr  = 32'd0;
        w_sel_wdata = 32'd0;
        w_sel_wstrb = 4'd0;
        if (r_grant[0]) begin
            w_sel_valid = m0_valid;
            w_sel_lock  = m0_lock;
            w_sel_addr  = m0_addr;
            w_sel_wdata = m0_wdata;
            w_sel_wstrb = m0_wstrb;
        end else if (r_grant[1]) begin
            w_sel_valid = m1_valid;
            w_sel_lock  = m1_lock;
            w_sel_addr  = m1_addr;
            w_sel_wdata = m1_wdata;
            w_sel_wstrb = m1_wstrb;
        end
    end

    // Expiry only counts when the slave has not answered; a same-cycle s_ready wins.
    assign w_busy       = (r_state == ST_BUSY) && w_sel_valid;
    assign w_expire     = WD_EN && w_busy && !s_ready && (r_wdog == WD_LIMIT);
    assign w_done       = w_busy && (s_ready || w_expire);
    assign w_done_rdata = s_ready ? s_rdata : ERR_RDATA;

    assign s_valid      = w_busy && !w_expire;
    assign s_addr       = w_sel_addr;
    assign s_wdata      = w_sel_wdata;
    assign s_wstrb      = w_sel_wstrb;
    assign grant        = r_grant;
    assign m0_ready     = w_done && r_grant[0];
    assign m1_ready     = w_done && r_grant[1];
    assign m0_rdata     = (w_done && r_grant[0]) ? w_done_rdata : 32'd0;
    assign m1_rdata     = (w_done && r_grant[1]) ? w_done_rdata : 32'd0;
    assign timeout_err  = r_timeout_err;
    assign timeout_addr = r_timeout_addr;

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_ptr_nxt   = r_ptr;
        w_wdog_clr  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (m0_valid || m1_valid) begin
                    w_state_nxt = ST_BUSY;
                    w_wdog_clr  = 1'b1;
                    // r_ptr = 0 favours m0; it then points at the master not just granted.
                    if (m0_valid && (!m1_valid || !r_ptr)) begin
                        w_grant_nxt = 2'b01;
                        w_ptr_nxt   = 1'b1;
                    end else begin
                        w_grant_nxt = 2'b10;
                        w_ptr_nxt   = 1'b0;
                    end
                end
            end
            ST_BUSY: begin
                if (!w_sel_valid) begin
                    w_state_nxt = ST_IDLE;
                    w_grant_nxt = 2'b00;
                end else if (w_done) begin
                    if (w_sel_lock) begin
                        w_state_nxt = ST_HOLD;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_grant_nxt = 2'b00;
                    end
                end
            end
            ST_HOLD: begin
                if (w_sel_valid) begin
                    w_state_nxt = ST_BUSY;
                    w_wdog_clr  = 1'b1;
                end else if (!w_sel_lock) begin
                    w_state_nxt = ST_IDLE;
                    w_grant_nxt = 2'b00;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = 2'b00;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_grant <= 2'b00;
            r_ptr   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wdog <= 32'd0;
        end else if (w_wdog_clr || !w_busy) begin
            r_wdog <= 32'd0;
        end else if (WD_EN && !s_ready) begin
            r_wdog <= r_wdog + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_timeout_err  <= 1'b0;
            r_timeout_addr <= 32'd0;
        end else if (w_expire) begin
            r_timeout_err  <= 1'b1;
            r_timeout_addr <= w_sel_addr;
        end else if (err_clear) begin
            r_timeout_err  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_picosoc_bus_arbiter.sv
// tb/tb_picosoc_bus_arbiter.sv - directed self-checking bench for picosoc_bus_arbiter
module tb_picosoc_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        m0_valid = 1'b0, m0_lock = 1'b0;
    logic [31:0] m0_addr = 32'd0, m0_wdata = 32'd0;
    logic [3:0]  m0_wstrb = 4'd0;
    logic        m0_ready;
    logic [31:0] m0_rdata;
    logic        m1_valid = 1'b0, m1_lock = 1'b0;
    logic [31:0] m1_addr = 32'd0, m1_wdata = 32'd0;
    logic [3:0]  m1_wstrb = 4'd0;
    logic        m1_ready;
    logic [31:0] m1_rdata;
    logic        s_valid;
    logic [31:0] s_addr, s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_ready = 1'b0;
    logic [31:0] s_rdata = 32'd0;
    logic [1:0]  grant;
    logic        err_clear = 1'b0;
    logic        timeout_err;
    logic [31:0] timeout_addr;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    picosoc_bus_arbiter #(.TIMEOUT_CYCLES(8), .ERR_RDATA(32'hDEAD_BEEF)) dut (
        .clk(clk), .reset(reset),
        .m0_valid(m0_valid), .m0_lock(m0_lock), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_wstrb(m0_wstrb), .m0_ready(m0_ready), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_lock(m1_lock), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_wstrb(m1_wstrb), .m1_ready(m1_ready), .m1_rdata(m1_rdata),
        .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_ready(s_ready), .s_rdata(s_rdata), .grant(grant),
        .err_clear(err_clear), .timeout_err(timeout_err), .timeout_addr(timeout_addr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Test 2: both masters always requesting, slave answers immediately.
    logic [1:0] t2_grant [8] = '{2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01};
    // Test 3: m1 locked burst while m0 waits.
    logic       t3_m1v   [10] = '{1, 1, 1, 1, 1, 1, 0, 0, 0, 0};
    logic       t3_m1l   [10] = '{1, 1, 1, 1, 1, 1, 1, 0, 0, 0};
    logic [1:0] t3_grant [10] = '{2'b00, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b01};
    logic       t3_sv    [10] = '{0, 1, 0, 1, 0, 1, 0, 0, 0, 1};
    logic       t3_m1r   [10] = '{0, 1, 0, 1, 0, 1, 0, 0, 0, 0};
    logic       t3_m0r   [10] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1};

    initial begin
        // reset state
        #1;
        chk("rst_grant", {30'd0, grant}, 32'd0);
        chk("rst_s_valid", {31'd0, s_valid}, 32'd0);
        chk("rst_m0_ready", {31'd0, m0_ready}, 32'd0);
        chk("rst_m0_rdata", m0_rdata, 32'd0);
        chk("rst_terr", {31'd0, timeout_err}, 32'd0);
        chk("rst_taddr", timeout_addr, 32'd0);
        @(negedge clk); reset = 1'b0;
        @(negedge clk);

        // Test 1: single m0 read, 3-cycle slave latency
        m0_valid = 1'b1; m0_addr = 32'h0000_0010; m0_wstrb = 4'h0; #1;
        chk("t1_arb_s_valid", {31'd0, s_valid}, 32'd0);
        @(negedge clk); #1;
        chk("t1_s_valid", {31'd0, s_valid}, 32'd1);
        chk("t1_grant", {30'd0, grant}, 32'd1);
        chk("t1_s_addr", s_addr, 32'h0000_0010);
        chk("t1_early_ready", {31'd0, m0_ready}, 32'd0);
        @(negedge clk); @(negedge clk);
        @(negedge clk); s_ready = 1'b1; s_rdata = 32'h1234_5678; #1;
        chk("t1_m0_ready", {31'd0, m0_ready}, 32'd1);
        chk("t1_m0_rdata", m0_rdata, 32'h1234_5678);
        chk("t1_m1_rdata", m1_rdata, 32'd0);
        @(negedge clk); m0_valid = 1'b0; s_ready = 1'b0; #1;
        chk("t1_ready_pulse", {31'd0, m0_ready}, 32'd0);
        chk("t1_grant_idle", {30'd0, grant}, 32'd0);
        chk("t1_s_addr_idle", s_addr, 32'd0);

        // Test 2: round-robin alternation (pointer now favours m1)
        @(negedge clk);
        m0_valid = 1'b1; m0_addr = 32'h0000_0100;
        m1_valid = 1'b1; m1_addr = 32'h0000_0200;
        s_ready = 1'b1; s_rdata = 32'hA5A5_0000;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            chk($sformatf("t2_grant_%0d", i), {30'd0, grant}, {30'd0, t2_grant[i]});
            chk($sformatf("t2_m0_ready_%0d", i), {31'd0, m0_ready}, {31'd0, t2_grant[i] == 2'b01});
            chk($sformatf("t2_m1_ready_%0d", i), {31'd0, m1_ready}, {31'd0, t2_grant[i] == 2'b10});
            if (t2_grant[i] == 2'b10) chk($sformatf("t2_s_addr_%0d", i), s_addr, 32'h0000_0200);
        end
        @(negedge clk); m0_valid = 1'b0; m1_valid = 1'b0; s_ready = 1'b0;

        // Test 3: m1 locked write burst, m0 waits
        @(negedge clk);
        m0_valid = 1'b1; m0_addr = 32'h0000_0300;
        m1_wstrb = 4'hF; m1_wdata = 32'h0000_0011; m1_addr = 32'h0000_0400;
        s_ready = 1'b1; s_rdata = 32'd0;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge clk);
            m1_valid = t3_m1v[i]; m1_lock = t3_m1l[i]; #1;
            chk($sformatf("t3_grant_%0d", i), {30'd0, grant}, {30'd0, t3_grant[i]});
            chk($sformatf("t3_s_valid_%0d", i), {31'd0, s_valid}, {31'd0, t3_sv[i]});
            chk($sformatf("t3_m1_ready_%0d", i), {31'd0, m1_ready}, {31'd0, t3_m1r[i]});
            chk($sformatf("t3_m0_ready_%0d", i), {31'd0, m0_ready}, {31'd0, t3_m0r[i]});
            if (i == 1) chk("t3_s_wstrb", {28'd0, s_wstrb}, 32'h0000_000F);
        end
        @(negedge clk); m0_valid = 1'b0; s_ready = 1'b0; m1_wstrb = 4'h0;

        // Test 4: watchdog expiry on the 8th BUSY cycle
        @(negedge clk);
        m0_valid = 1'b1; m0_addr = 32'h0200_0100; #1;
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk); #1;
            chk($sformatf("t4_wait_s_valid_%0d", i), {31'd0, s_valid}, 32'd1);
            chk($sformatf("t4_wait_ready_%0d", i), {31'd0, m0_ready}, 32'd0);
        end
        @(negedge clk); #1;
        chk("t4_exp_s_valid", {31'd0, s_valid}, 32'd0);
        chk("t4_exp_ready", {31'd0, m0_ready}, 32'd1);
        chk("t4_exp_rdata", m0_rdata, 32'hDEAD_BEEF);
        chk("t4_exp_terr_pre", {31'd0, timeout_err}, 32'd0);
        @(negedge clk); m0_valid = 1'b0; err_clear = 1'b1; #1;
        chk("t4_terr", {31'd0, timeout_err}, 32'd1);
        chk("t4_taddr", timeout_addr, 32'h0200_0100);
        chk("t4_grant_idle", {30'd0, grant}, 32'd0);
        @(negedge clk); err_clear = 1'b0; #1;
        chk("t4_terr_cleared", {31'd0, timeout_err}, 32'd0);
        chk("t4_taddr_kept", timeout_addr, 32'h0200_0100);

        // Test 5: s_ready in the expiry cycle wins
        @(negedge clk);
        m0_valid = 1'b1; m0_addr = 32'h0000_0500;
        for (int i = 1; i <= 7; i++) @(negedge clk);
        @(negedge clk); s_ready = 1'b1; s_rdata = 32'hCAFE_F00D; #1;
        chk("t5_ready", {31'd0, m0_ready}, 32'd1);
        chk("t5_rdata", m0_rdata, 32'hCAFE_F00D);
        chk("t5_s_valid", {31'd0, s_valid}, 32'd1);
        @(negedge clk); m0_valid = 1'b0; s_ready = 1'b0; #1;
        chk("t5_terr", {31'd0, timeout_err}, 32'd0);
        chk("t5_taddr", timeout_addr, 32'h0200_0100);

        // Test 6: asynchronous reset mid-access (pointer favours m1 beforehand)
        @(negedge clk);
        m0_valid = 1'b1; m0_addr = 32'h0000_0600;
        m1_valid = 1'b1; m1_addr = 32'h0000_0700;
        @(negedge clk); #1;
        chk("t6_pre_grant", {30'd0, grant}, 32'd2);
        chk("t6_pre_s_valid", {31'd0, s_valid}, 32'd1);
        #1; s_ready = 1'b1; reset = 1'b1; #1;
        chk("t6_rst_grant", {30'd0, grant}, 32'd0);
        chk("t6_rst_s_valid", {31'd0, s_valid}, 32'd0);
        chk("t6_rst_m1_ready", {31'd0, m1_ready}, 32'd0);
        chk("t6_rst_m1_rdata", m1_rdata, 32'd0);
        chk("t6_rst_s_addr", s_addr, 32'd0);
        @(negedge clk); reset = 1'b0; s_ready = 1'b0; #1;
        chk("t6_rel_grant", {30'd0, grant}, 32'd0);
        @(negedge clk); #1;
        chk("t6_rearb_grant", {30'd0, grant}, 32'd1);
        chk("t6_rearb_s_addr", s_addr, 32'h0000_0600);
        m0_valid = 1'b0; m1_valid = 1'b0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/picosoc_bus_arbiter.md
Name: picosoc_bus_arbiter

Overview:
- Two-master arbiter that shares one native memory bus (valid/ready/addr/wdata/wstrb/rdata) between the CPU (m0) and a second master such as DMA or debug (m1).
- Sits between the masters and the SoC address decoder: RAM, SPI flash, UART and iomem.
- Provides round-robin arbitration, optional lock for atomic multi-access sequences, and a watchdog that force-completes hung slave accesses.

Parameters:
- TIMEOUT_CYCLES, 1024, slave wait cycles before forced completion; 0 disables the watchdog.
- ERR_RDATA, 32'hDEAD_BEEF, rdata returned to the master on a timed-out access.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- m0_valid/m1_valid  in  1  master request, held until ready
- m0_lock/m1_lock  in  1  keep grant after the current access completes
- m0_addr/m1_addr  in  32  address
- m0_wdata/m1_wdata  in  32  write data
- m0_wstrb/m1_wstrb  in  4  byte strobes; 0 = read
- m0_ready/m1_ready  out  1  one-cycle completion pulse
- m0_rdata/m1_rdata  out  32  read data, valid when ready
- s_valid  out  1  request to slave side
- s_addr/s_wdata/s_wstrb  out  32/32/4  muxed from the granted master
- s_ready  in  1  slave completion
- s_rdata  in  32  slave read data
- grant  out  2  one-hot owner; 00 = none
- err_clear  in  1  clears the sticky timeout flag
- timeout_err  out  1  sticky timeout flag
- timeout_addr  out  32  address of the most recent timed-out access

Behaviour:
Interface and reset:
- One clock; reset is asynchronous and active-high.
- Reset values: state IDLE, grant 00, s_valid 0, m*_ready 0, m*_rdata 0, timeout_err 0, timeout_addr 0, priority pointer favours m0, watchdog counter 0.
- Reset mid-access aborts the access immediately; no ready is issued to the master.

States IDLE, BUSY, HOLD:
- IDLE: s_valid 0, grant 00.
  - If any mX_valid, register grant and go to BUSY.
  - Both requesting: grant the master the pointer favours. Pointer flips to the other master each time a grant is taken from IDLE.
  - Arbitration costs exactly 1 cycle: s_valid rises the cycle after mX_valid is first seen.
- BUSY:
  - s_valid = granted mX_valid.
  - s_addr/s_wdata/s_wstrb = the granted master's signals, combinational.
  - On s_ready: granted mX_ready = 1 and mX_rdata = s_rdata in the same cycle (combinational), then:
    - mX_lock = 1 → HOLD.
    - mX_lock = 0 → IDLE.
  - Back-to-back accesses without lock re-arbitrate with 1 idle cycle.
  - If the granted master drops valid without ready (protocol violation): go to IDLE, no ready, watchdog cleared.
- HOLD: grant kept, s_valid 0.
  - Granted mX_valid → BUSY next cycle.
  - mX_lock = 0 and no valid → IDLE.
  - The other master waits indefinitely while HOLD persists.

Output rules:
- Non-granted mX_ready = 0 and mX_rdata = 0 at all times.
- s_addr/s_wdata/s_wstrb = 0 when grant = 00.

Watchdog:
- Counter clears on entry to BUSY and increments each BUSY cycle without s_ready.
- When it reaches TIMEOUT_CYCLES with s_ready still 0:
  - s_valid drops in that cycle.
  - Master gets mX_ready = 1 with mX_rdata = ERR_RDATA.
  - timeout_err set; timeout_addr = s_addr.
  - Next state follows the lock rule above.
- s_ready arriving in the same cycle as expiry wins: normal completion, no error.
- err_clear clears timeout_err next cycle; a simultaneous new timeout wins (flag stays 1, address updated).
- TIMEOUT_CYCLES = 0: counter inert, timeout never fires.

Test Plan:
- Reset release, m0 read at 0x0000_0010; slave returns s_ready with 0x1234_5678 three cycles after s_valid → s_valid 1 cycle after m0_valid, m0_ready single pulse with rdata 0x1234_5678, grant 01→00.
- m0 and m1 request in the same cycle, both continuously, slave 1-cycle ready → grants alternate 01,10,01,10; each access has 1 idle arbitration cycle.
- m1 sets lock across three writes (wstrb 4'hF) while m0 requests → grant stays 10 through HOLD; m0 granted only after m1_lock = 0 and no m1_valid.
- TIMEOUT_CYCLES = 8, s_ready tied 0, m0 read of 0x0200_0100 → m0_ready on the 8th BUSY cycle with rdata 0xDEAD_BEEF, timeout_err = 1, timeout_addr = 0x0200_0100; err_clear → 0.
- s_ready coincides with the expiry cycle → normal rdata, timeout_err stays 0.
- Assert reset while BUSY with s_valid high → all outputs zero asynchronously, no mX_ready; after release, the pending request is re-arbitrated starting with m0 priority.
